// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants for the SRAM request arbiter: requester ids, size codes, default depth.
`default_nettype none

package sram_arb_pkg;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int DEFAULT_MAX_OUTSTANDING = 4;

endpackage

`default_nettype wire

// File: rtl/owner_tag_fifo.sv
// Circular FIFO of 1-bit owner tags, one entry per accepted but not yet returned request.
`default_nettype none

module owner_tag_fifo
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_MAX_OUTSTANDING
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_id;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between IF and MEM requesters, routing data_ok by acceptance order.
// Optional round-robin arbitration when ARB_ROUND_ROBIN_EN is defined (fixed data priority otherwise).
`default_nettype none

module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [3:0]        inst_sram_wstrb,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [ADDR_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [ADDR_W-1:0] inst_sram_rdata,

  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [ADDR_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [ADDR_W-1:0] data_sram_rdata,

  output logic              slv_sram_req,
  output logic              slv_sram_wr,
  output logic [1:0]        slv_sram_size,
  output logic [3:0]        slv_sram_wstrb,
  output logic [ADDR_W-1:0] slv_sram_addr,
  output logic [ADDR_W-1:0] slv_sram_wdata,
  input  logic              slv_sram_addr_ok,
  input  logic              slv_sram_data_ok,
  input  logic [ADDR_W-1:0] slv_sram_rdata
);

  logic lock_valid;
  logic lock_id;
  logic grant_valid;
  logic grant_id;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_head;
  logic accept;
  logic ret;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last;
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_INST;
    if (!reset && !fifo_full) begin
      // A stalled request must stay on the bus unchanged until the slave takes it.
      if (lock_valid && ((lock_id == REQ_DATA) ? data_sram_req : inst_sram_req)) begin
        grant_valid = 1'b1;
        grant_id    = lock_id;
      end else if (data_sram_req && inst_sram_req) begin
        grant_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        grant_id    = ~rr_last;
`else
        grant_id    = REQ_DATA;
`endif
      end else if (data_sram_req) begin
        grant_valid = 1'b1;
        grant_id    = REQ_DATA;
      end else if (inst_sram_req) begin
        grant_valid = 1'b1;
        grant_id    = REQ_INST;
      end
    end
  end

  always_comb begin
    slv_sram_req   = grant_valid;
    slv_sram_wr    = 1'b0;
    slv_sram_size  = '0;
    slv_sram_wstrb = '0;
    slv_sram_addr  = '0;
    slv_sram_wdata = '0;
    if (grant_valid) begin
      if (grant_id == REQ_DATA) begin
        slv_sram_wr    = data_sram_wr;
        slv_sram_size  = data_sram_size;
        slv_sram_wstrb = data_sram_wstrb;
        slv_sram_addr  = data_sram_addr;
        slv_sram_wdata = data_sram_wdata;
      end else begin
        slv_sram_wr    = inst_sram_wr;
        slv_sram_size  = inst_sram_size;
        slv_sram_wstrb = inst_sram_wstrb;
        slv_sram_addr  = inst_sram_addr;
        slv_sram_wdata = inst_sram_wdata;
      end
    end
  end

  assign accept            = slv_sram_req & slv_sram_addr_ok;
  assign inst_sram_addr_ok = accept & (grant_id == REQ_INST);
  assign data_sram_addr_ok = accept & (grant_id == REQ_DATA);

  assign ret               = slv_sram_data_ok & ~fifo_empty & ~reset;
  assign inst_sram_data_ok = ret & (fifo_head == REQ_INST);
  assign data_sram_data_ok = ret & (fifo_head == REQ_DATA);
  assign inst_sram_rdata   = slv_sram_rdata;
  assign data_sram_rdata   = slv_sram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_id    <= REQ_INST;
    end else begin
      lock_valid <= grant_valid & ~slv_sram_addr_ok;
      lock_id    <= grant_id;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= REQ_INST;
    end else if (accept) begin
      rr_last <= grant_id;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && slv_sram_data_ok) begin
      assert (!fifo_empty) else $info("sram_req_arbiter: data_ok with no outstanding request ignored");
    end
  end
`endif

  owner_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .push_id (grant_id),
    .pop     (ret),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

endmodule

`default_nettype wire
